// File: rtl/game_phase_controller.sv
// Round sequencer for a symbol-counting game: countdown, symbol burst, answer window,
// and a four-page result display that either advances the level or returns to idle.
module game_phase_controller #(
    parameter int PRELIM_SECS = 5,
    parameter int ANSWER_SECS = 9,
    parameter int SYM_BASE    = 8,
    parameter int MAX_LEVEL   = 31
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Tick1Hz,
    input  logic       Start,
    input  logic       SymTick,
    input  logic       AnswerDone,
    input  logic [7:0] UserCount,
    input  logic [7:0] GameCount,
    output logic       prelimPeriod,
    output logic       gamePeriod,
    output logic       answerPeriod,
    output logic       postPeriod,
    output logic [3:0] countDownTime,
    output logic [4:0] level,
    output logic       genEnable,
    output logic [1:0] postStep,
    output logic [7:0] diff,
    output logic       win
);

    localparam logic [3:0] PRELIM_LOAD = 4'(PRELIM_SECS);
    localparam logic [3:0] ANSWER_LOAD = 4'(ANSWER_SECS);
    localparam logic [7:0] SYM_BASE_B  = 8'(SYM_BASE);
    localparam logic [4:0] LEVEL_CAP   = 5'(MAX_LEVEL);

    typedef enum logic [2:0] {
        IDLE,
        PRELIM,
        GAME,
        ANSWER,
        POST
    } state_t;

    state_t     state;
    logic [7:0] sym_issued;
    logic [7:0] sym_target;
    logic [7:0] sym_next;
    logic       answer_exit;
    logic [7:0] count_diff;

    // Target grows by two symbols per level; at level 31 this is 70, well inside 8 bits.
    always_comb begin
        sym_target  = SYM_BASE_B + {2'b00, level, 1'b0};
        sym_next    = sym_issued + 8'd1;
        answer_exit = AnswerDone || (Tick1Hz && (countDownTime == 4'd0));
        count_diff  = (UserCount >= GameCount) ? (UserCount - GameCount)
                                               : (GameCount - UserCount);
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state         <= IDLE;
            prelimPeriod  <= 1'b0;
            gamePeriod    <= 1'b0;
            answerPeriod  <= 1'b0;
            postPeriod    <= 1'b0;
            genEnable     <= 1'b0;
            countDownTime <= 4'd0;
            level         <= 5'd0;
            postStep      <= 2'd0;
            diff          <= 8'd0;
            win           <= 1'b0;
            sym_issued    <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        state         <= PRELIM;
                        prelimPeriod  <= 1'b1;
                        countDownTime <= PRELIM_LOAD;
                    end
                end
                PRELIM: begin
                    if (Tick1Hz) begin
                        if (countDownTime != 4'd0) begin
                            countDownTime <= countDownTime - 4'd1;
                        end else begin
                            state        <= GAME;
                            prelimPeriod <= 1'b0;
                            gamePeriod   <= 1'b1;
                            genEnable    <= 1'b1;
                            sym_issued   <= 8'd0;
                        end
                    end
                end
                GAME: begin
                    if (SymTick) begin
                        sym_issued <= sym_next;
                        if (sym_next >= sym_target) begin
                            state         <= ANSWER;
                            gamePeriod    <= 1'b0;
                            genEnable     <= 1'b0;
                            answerPeriod  <= 1'b1;
                            countDownTime <= ANSWER_LOAD;
                        end
                    end
                end
                ANSWER: begin
                    // A commit and a timeout tick on the same edge collapse into one exit.
                    if (answer_exit) begin
                        state         <= POST;
                        answerPeriod  <= 1'b0;
                        postPeriod    <= 1'b1;
                        countDownTime <= 4'd0;
                        postStep      <= 2'd0;
                        diff          <= count_diff;
                        win           <= (count_diff == 8'd0);
                    end else if (Tick1Hz) begin
                        countDownTime <= countDownTime - 4'd1;
                    end
                end
                POST: begin
                    if (Tick1Hz) begin
                        if (postStep == 2'd3) begin
                            postStep   <= 2'd0;
                            postPeriod <= 1'b0;
                            if (win) begin
                                state         <= PRELIM;
                                prelimPeriod  <= 1'b1;
                                countDownTime <= PRELIM_LOAD;
                                level         <= (level >= LEVEL_CAP) ? level : level + 5'd1;
                            end else begin
                                state <= IDLE;
                                level <= 5'd0;
                            end
                        end else begin
                            postStep <= postStep + 2'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_game_phase_controller.sv
// Randomised and directed bench for game_phase_controller, checked against a
// phase-level model of the game rules kept in this file.
module tb_game_phase_controller;

    localparam int PRELIM_SECS = 5;
    localparam int ANSWER_SECS = 9;
    localparam int SYM_BASE    = 8;
    localparam int MAX_LEVEL   = 31;

    localparam int P_IDLE   = 0;
    localparam int P_PRELIM = 1;
    localparam int P_GAME   = 2;
    localparam int P_ANSWER = 3;
    localparam int P_POST   = 4;

    logic       Clk;
    logic       Rst;
    logic       Tick1Hz;
    logic       Start;
    logic       SymTick;
    logic       AnswerDone;
    logic [7:0] UserCount;
    logic [7:0] GameCount;
    logic       prelimPeriod;
    logic       gamePeriod;
    logic       answerPeriod;
    logic       postPeriod;
    logic [3:0] countDownTime;
    logic [4:0] level;
    logic       genEnable;
    logic [1:0] postStep;
    logic [7:0] diff;
    logic       win;

    int n_checks;
    int n_fail;

    int m_phase;
    int m_cdt;
    int m_level;
    int m_issued;
    int m_step;
    int m_diff;
    bit m_win;

    game_phase_controller #(
        .PRELIM_SECS(PRELIM_SECS),
        .ANSWER_SECS(ANSWER_SECS),
        .SYM_BASE   (SYM_BASE),
        .MAX_LEVEL  (MAX_LEVEL)
    ) dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Tick1Hz      (Tick1Hz),
        .Start        (Start),
        .SymTick      (SymTick),
        .AnswerDone   (AnswerDone),
        .UserCount    (UserCount),
        .GameCount    (GameCount),
        .prelimPeriod (prelimPeriod),
        .gamePeriod   (gamePeriod),
        .answerPeriod (answerPeriod),
        .postPeriod   (postPeriod),
        .countDownTime(countDownTime),
        .level        (level),
        .genEnable    (genEnable),
        .postStep     (postStep),
        .diff         (diff),
        .win          (win)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    function automatic void model_reset();
        m_phase  = P_IDLE;
        m_cdt    = 0;
        m_level  = 0;
        m_issued = 0;
        m_step   = 0;
        m_diff   = 0;
        m_win    = 1'b0;
    endfunction

    // Game rules applied to one clock edge worth of input pulses.
    function automatic void model_step(logic tk, logic st, logic sy, logic dn,
                                       logic [7:0] uc, logic [7:0] gc);
        case (m_phase)
            P_IDLE: if (st) begin m_phase = P_PRELIM; m_cdt = PRELIM_SECS; end
            P_PRELIM: if (tk) begin
                if (m_cdt > 0) m_cdt--;
                else begin m_phase = P_GAME; m_issued = 0; end
            end
            P_GAME: if (sy) begin
                m_issued++;
                if (m_issued == SYM_BASE + 2 * m_level) begin
                    m_phase = P_ANSWER;
                    m_cdt   = ANSWER_SECS;
                end
            end
            P_ANSWER: begin
                if (dn || (tk && m_cdt == 0)) begin
                    m_phase = P_POST;
                    m_step  = 0;
                    m_diff  = (uc > gc) ? int'(uc) - int'(gc) : int'(gc) - int'(uc);
                    m_win   = (m_diff == 0);
                end else if (tk) begin
                    m_cdt--;
                end
            end
            P_POST: if (tk) begin
                if (m_step == 3) begin
                    if (m_win) begin
                        m_level = (m_level < MAX_LEVEL) ? m_level + 1 : MAX_LEVEL;
                        m_phase = P_PRELIM;
                        m_cdt   = PRELIM_SECS;
                    end else begin
                        m_level = 0;
                        m_phase = P_IDLE;
                    end
                end else begin
                    m_step++;
                end
            end
            default: ;
        endcase
    endfunction

    // diff and win are only meaningful while the result pages are shown.
    function automatic logic [24:0] exp_vec();
        logic in_post;
        logic [3:0] cdt;
        in_post = (m_phase == P_POST);
        cdt = (m_phase == P_PRELIM || m_phase == P_ANSWER) ? 4'(m_cdt) : 4'd0;
        return {(m_phase == P_PRELIM), (m_phase == P_GAME), (m_phase == P_ANSWER), in_post,
                (m_phase == P_GAME), cdt, 5'(m_level),
                in_post ? 2'(m_step) : 2'd0, in_post ? 8'(m_diff) : 8'd0,
                in_post ? m_win : 1'b0};
    endfunction

    function automatic logic [24:0] obs_vec();
        logic in_post;
        in_post = (m_phase == P_POST);
        return {prelimPeriod, gamePeriod, answerPeriod, postPeriod, genEnable,
                countDownTime, level, postStep,
                in_post ? diff : 8'd0, in_post ? win : 1'b0};
    endfunction

    task automatic drive(input logic tk, input logic st, input logic sy, input logic dn,
                         input logic [7:0] uc, input logic [7:0] gc);
        Tick1Hz    = tk;
        Start      = st;
        SymTick    = sy;
        AnswerDone = dn;
        UserCount  = uc;
        GameCount  = gc;
        model_step(tk, st, sy, dn, uc, gc);
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        Tick1Hz = 1'b0; Start = 1'b0; SymTick = 1'b0; AnswerDone = 1'b0;
        UserCount = 8'd0; GameCount = 8'd0;
        model_reset();
        repeat (2) @(posedge Clk);
        #1;
        n_checks++;
        if ({prelimPeriod, gamePeriod, answerPeriod, postPeriod, genEnable} !== 5'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_flags got=%b want=00000",
                     {prelimPeriod, gamePeriod, answerPeriod, postPeriod, genEnable});
        end
        n_checks++;
        if ({countDownTime, level, postStep, diff, win} !== 20'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_values got=%h want=0",
                     {countDownTime, level, postStep, diff, win});
        end
        Rst = 1'b0;
        drive(0, 0, 0, 0, 8'd0, 8'd0);
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("[TB] FAIL reset_idle got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_prelim();
        drive(0, 1, 0, 0, 8'd0, 8'd0);
        n_checks++;
        if (!(prelimPeriod === 1'b1 && countDownTime === 4'd5)) begin
            n_fail++;
            $display("[TB] FAIL prelim_load got=%b/%0d want=1/5", prelimPeriod, countDownTime);
        end
        for (int k = 4; k >= 0; k--) begin
            repeat ($urandom_range(0, 2)) drive(0, 1, 1, 0, 8'd0, 8'd0);
            drive(1, 0, 0, 0, 8'd0, 8'd0);
            n_checks++;
            if (!(prelimPeriod === 1'b1 && countDownTime === 4'(k))) begin
                n_fail++;
                $display("[TB] FAIL prelim_count got=%b/%0d want=1/%0d",
                         prelimPeriod, countDownTime, k);
            end
        end
        drive(1, 0, 0, 0, 8'd0, 8'd0);
        n_checks++;
        if (!(gamePeriod === 1'b1 && genEnable === 1'b1 && prelimPeriod === 1'b0
              && countDownTime === 4'd0)) begin
            n_fail++;
            $display("[TB] FAIL prelim_to_game got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_game();
        for (int i = 1; i <= 8; i++) begin
            repeat ($urandom_range(0, 2)) drive(1, 1, 0, 0, 8'd0, 8'd0);
            drive(0, 0, 1, 0, 8'd0, 8'd0);
            if (i < 8) begin
                n_checks++;
                if (!(gamePeriod === 1'b1 && genEnable === 1'b1 && answerPeriod === 1'b0)) begin
                    n_fail++;
                    $display("[TB] FAIL game_hold sym=%0d got=%h want=%h", i, obs_vec(), exp_vec());
                end
            end
        end
        n_checks++;
        if (!(answerPeriod === 1'b1 && countDownTime === 4'd9 && genEnable === 1'b0
              && gamePeriod === 1'b0)) begin
            n_fail++;
            $display("[TB] FAIL game_to_answer got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_post_lose();
        drive(1, 0, 0, 0, 8'd0, 8'd0);
        drive(1, 0, 0, 0, 8'd0, 8'd0);
        n_checks++;
        if (countDownTime !== 4'd7) begin
            n_fail++;
            $display("[TB] FAIL answer_count got=%0d want=7", countDownTime);
        end
        drive(0, 0, 0, 1, 8'd12, 8'd9);
        n_checks++;
        if (!(postPeriod === 1'b1 && postStep === 2'd0 && diff === 8'd3 && win === 1'b0)) begin
            n_fail++;
            $display("[TB] FAIL post_entry got=%b/%0d/%0d/%b want=1/0/3/0",
                     postPeriod, postStep, diff, win);
        end
        for (int s = 1; s <= 3; s++) begin
            drive(1, 0, 0, 0, 8'd0, 8'd0);
            n_checks++;
            if (!(postPeriod === 1'b1 && postStep === 2'(s) && diff === 8'd3)) begin
                n_fail++;
                $display("[TB] FAIL post_step got=%0d want=%0d", postStep, s);
            end
        end
        drive(1, 0, 0, 0, 8'd0, 8'd0);
        n_checks++;
        if ({prelimPeriod, gamePeriod, answerPeriod, postPeriod, level, postStep} !== 11'd0) begin
            n_fail++;
            $display("[TB] FAIL post_lose_idle got=%h want=0",
                     {prelimPeriod, gamePeriod, answerPeriod, postPeriod, level, postStep});
        end
    endtask

    // Plays one round from PRELIM through POST, checking every cycle against the model.
    task automatic play_round(input logic [7:0] uc, input logic [7:0] gc);
        int guard;
        guard = 0;
        while (m_phase != P_ANSWER && guard < 200) begin
            if (m_phase == P_PRELIM) drive(1, 0, 0, 0, 8'd0, 8'd0);
            else drive(0, 0, 1, 0, 8'd0, 8'd0);
            guard++;
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL round_vec got=%h want=%h", obs_vec(), exp_vec());
            end
        end
        drive(0, 0, 0, 1, uc, gc);
        while (m_phase == P_POST && guard < 220) begin
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL round_post got=%h want=%h", obs_vec(), exp_vec());
            end
            drive(1, 0, 0, 0, 8'd0, 8'd0);
            guard++;
        end
        if (guard >= 200) begin
            n_checks++;
            n_fail++;
            $display("[TB] FAIL round_guard got=%0d cycles want<200", guard);
        end
    endtask

    task automatic test_win_max_level();
        drive(0, 1, 0, 0, 8'd0, 8'd0);
        for (int r = 0; r < MAX_LEVEL; r++) begin
            play_round(8'(r), 8'(r));
        end
        n_checks++;
        if (!(level === 5'd31 && prelimPeriod === 1'b1)) begin
            n_fail++;
            $display("[TB] FAIL climb_level got=%0d want=31", level);
        end
        play_round(8'd7, 8'd7);
        n_checks++;
        if (!(level === 5'd31 && prelimPeriod === 1'b1 && countDownTime === 4'd5)) begin
            n_fail++;
            $display("[TB] FAIL max_level_hold got=%0d/%b/%0d want=31/1/5",
                     level, prelimPeriod, countDownTime);
        end
        repeat (6) drive(1, 0, 0, 0, 8'd0, 8'd0);
        for (int i = 1; i <= 69; i++) drive(0, 0, 1, 0, 8'd0, 8'd0);
        n_checks++;
        if (!(gamePeriod === 1'b1 && answerPeriod === 1'b0)) begin
            n_fail++;
            $display("[TB] FAIL max_target_69 got=%h want=%h", obs_vec(), exp_vec());
        end
        drive(0, 0, 1, 0, 8'd0, 8'd0);
        n_checks++;
        if (!(answerPeriod === 1'b1 && gamePeriod === 1'b0 && countDownTime === 4'd9)) begin
            n_fail++;
            $display("[TB] FAIL max_target_70 got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_simultaneous();
        repeat (9) drive(1, 0, 0, 0, 8'd0, 8'd0);
        n_checks++;
        if (!(answerPeriod === 1'b1 && countDownTime === 4'd0)) begin
            n_fail++;
            $display("[TB] FAIL answer_zero got=%b/%0d want=1/0", answerPeriod, countDownTime);
        end
        drive(1, 0, 0, 1, 8'd1, 8'd200);
        n_checks++;
        if (!(postPeriod === 1'b1 && answerPeriod === 1'b0 && postStep === 2'd0
              && diff === 8'd199 && win === 1'b0)) begin
            n_fail++;
            $display("[TB] FAIL simul_entry got=%h want=%h", obs_vec(), exp_vec());
        end
        drive(1, 0, 0, 1, 8'd0, 8'd0);
        n_checks++;
        if (!(postPeriod === 1'b1 && postStep === 2'd1 && diff === 8'd199)) begin
            n_fail++;
            $display("[TB] FAIL simul_single got=%h want=%h", obs_vec(), exp_vec());
        end
        repeat (3) drive(1, 0, 0, 0, 8'd0, 8'd0);
        n_checks++;
        if (obs_vec() !== exp_vec() || level !== 5'd0 || postPeriod !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL simul_idle got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid_game();
        drive(0, 1, 0, 0, 8'd0, 8'd0);
        repeat (6) drive(1, 0, 0, 0, 8'd0, 8'd0);
        repeat (3) drive(0, 0, 1, 0, 8'd0, 8'd0);
        Tick1Hz = 1'b0; Start = 1'b0; SymTick = 1'b0; AnswerDone = 1'b0;
        Rst = 1'b1;
        model_reset();
        #2;
        n_checks++;
        if ({prelimPeriod, gamePeriod, answerPeriod, postPeriod, genEnable,
             countDownTime, level, postStep, diff, win} !== 25'd0) begin
            n_fail++;
            $display("[TB] FAIL async_reset got=%h want=0",
                     {prelimPeriod, gamePeriod, answerPeriod, postPeriod, genEnable,
                      countDownTime, level, postStep, diff, win});
        end
        @(posedge Clk);
        #1;
        Rst = 1'b0;
        drive(0, 1, 0, 0, 8'd0, 8'd0);
        n_checks++;
        if (!(prelimPeriod === 1'b1 && countDownTime === 4'd5)) begin
            n_fail++;
            $display("[TB] FAIL start_after_reset got=%b/%0d want=1/5", prelimPeriod, countDownTime);
        end
        play_round(8'd3, 8'd4);
        n_checks++;
        if (obs_vec() !== exp_vec() || prelimPeriod !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_game_end got=%h want=%h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        logic tk, st, sy, dn;
        logic [7:0] uc, gc;
        for (int c = 0; c < 4000; c++) begin
            tk = ($urandom_range(0, 2) == 0);
            st = ($urandom_range(0, 7) == 0);
            sy = ($urandom_range(0, 1) == 0);
            dn = ($urandom_range(0, 9) == 0);
            uc = 8'($urandom_range(0, 15));
            gc = ($urandom_range(0, 1) == 0) ? uc : 8'($urandom_range(0, 255));
            drive(tk, st, sy, dn, uc, gc);
            n_checks++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("[TB] FAIL random_vec cycle=%0d got=%h want=%h", c, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_prelim();
        test_game();
        test_post_lose();
        test_win_max_level();
        test_simultaneous();
        test_reset_mid_game();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
